// File: rtl/icache_assoc_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_assoc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int unsigned WORD_W = 32;

  // Address field width for a power-of-two count; zero when the field vanishes.
  function automatic int unsigned fld_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned reg_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-set age-based true-LRU tracker: age 0 is MRU, the oldest way is the victim.
module icache_lru import icache_assoc_pkg::*; #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned SETS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [fld_w(SETS)-1:0] i_idx,
  input  logic [reg_w(WAYS)-1:0] i_way,
  input  logic                   i_touch,
  output logic [reg_w(WAYS)-1:0] o_victim
);

  localparam int unsigned AGE_W = reg_w(WAYS);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  logic [AGE_W-1:0] r_age [SETS][WAYS];
  logic [AGE_W-1:0] w_max;

  // Oldest way at the addressed set; ties resolve to the lowest way.
  always_comb begin
    o_victim = '0;
    w_max    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[i_idx][w] > w_max) begin
        w_max    = r_age[i_idx][w];
        o_victim = AGE_W'(w);
      end
    end
  end

  // Touched way becomes MRU; ways no older than it age by one (saturating).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w] <= '0;
        end
      end
    end else if (i_touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == i_way) begin
          r_age[i_idx][w] <= '0;
        end else if ((r_age[i_idx][w] <= r_age[i_idx][i_way]) && (r_age[i_idx][w] != AGE_MAX)) begin
          r_age[i_idx][w] <= r_age[i_idx][w] + AGE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hits, word-by-word block fill on a miss.
module icache_assoc import icache_assoc_pkg::*; #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SETS  = 8,
  parameter int unsigned WORDS = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [31:0]       imemaddr,
  input  logic              dmem_busy,
  input  logic              iflush,
  output logic              ihit,
  output logic [31:0]       imemload,
  output logic              iREN,
  output logic [31:0]       iaddr,
  input  logic              iwait,
  input  logic [31:0]       iload,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned OFF_W = fld_w(WORDS);
  localparam int unsigned IDX_W = fld_w(SETS);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
  localparam int unsigned OFF_S = reg_w(WORDS);
  localparam int unsigned WAY_S = reg_w(WAYS);

  typedef struct packed {
    logic                         valid;
    logic [TAG_W-1:0]             tag;
    logic [WORDS-1:0][WORD_W-1:0] data;
  } line_t;

  line_t            r_lines [WAYS][SETS];
  state_t           r_state;
  state_t           w_state_nxt;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [OFF_S-1:0] r_wcnt;
  logic [WAY_S-1:0] r_victim;
  logic [CNT_W-1:0] r_hits;
  logic [CNT_W-1:0] r_misses;

  logic [31:0]      w_waddr;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_S-1:0] w_off;
  logic             w_hit_any;
  logic [WAY_S-1:0] w_hit_way;
  logic [31:0]      w_hit_word;
  logic             w_inv_any;
  logic [WAY_S-1:0] w_inv_way;
  logic [WAY_S-1:0] w_lru_victim;
  logic [WAY_S-1:0] w_new_victim;
  logic             w_idle;
  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic             w_touch;

  assign w_waddr = imemaddr >> 2;
  assign w_off   = OFF_S'(w_waddr & 32'(WORDS - 1));
  assign w_idx   = IDX_W'((w_waddr >> OFF_W) & 32'(SETS - 1));
  assign w_tag   = TAG_W'(w_waddr >> (OFF_W + IDX_W));

  // Tag compare across the ways of the addressed set.
  always_comb begin
    w_hit_any  = 1'b0;
    w_hit_way  = '0;
    w_hit_word = 32'h0000_0000;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit_any && r_lines[w][w_idx].valid && (r_lines[w][w_idx].tag == w_tag)) begin
        w_hit_any  = 1'b1;
        w_hit_way  = WAY_S'(w);
        w_hit_word = r_lines[w][w_idx].data[w_off];
      end
    end
  end

  // Lowest-numbered invalid way, preferred over the LRU victim.
  always_comb begin
    w_inv_any = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_lines[w][w_idx].valid) begin
        w_inv_any = 1'b1;
        w_inv_way = WAY_S'(w);
      end
    end
  end

  assign w_idle       = (r_state == IDLE);
  assign w_start      = w_idle && imemREN && !w_hit_any && !dmem_busy && !iflush;
  assign w_accept     = (r_state == FILL) && !iwait;
  assign w_last       = w_accept && (r_wcnt == OFF_S'(WORDS - 1));
  assign w_new_victim = w_inv_any ? w_inv_way : w_lru_victim;
  assign w_touch      = ihit || (w_last && !iflush);

  assign ihit       = w_idle && imemREN && w_hit_any && !iflush;
  assign imemload   = ihit ? w_hit_word : 32'h0000_0000;
  assign iREN       = (r_state == FILL);
  assign iaddr      = iREN ? (((((32'(r_tag) << IDX_W) | 32'(r_idx)) << OFF_W) | 32'(r_wcnt)) << 2)
                           : 32'h0000_0000;
  assign hit_count  = r_hits;
  assign miss_count = r_misses;

  icache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_idx    (w_idle ? w_idx : r_idx),
    .i_way    (ihit ? w_hit_way : r_victim),
    .i_touch  (w_touch),
    .o_victim (w_lru_victim)
  );

  // Next state: a flush always wins and abandons an unfinished fill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = FILL;
        else         w_state_nxt = IDLE;
      end
      FILL: begin
        if (iflush || w_last) w_state_nxt = IDLE;
        else                  w_state_nxt = FILL;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, miss capture, line writes and performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_tag    <= '0;
      r_idx    <= '0;
      r_wcnt   <= '0;
      r_victim <= '0;
      r_hits   <= '0;
      r_misses <= '0;
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          r_lines[w][s] <= '0;
        end
      end
    end else begin
      r_state <= w_state_nxt;
      if (ihit) begin
        r_hits <= r_hits + CNT_W'(1);
      end
      if (w_start) begin
        r_tag    <= w_tag;
        r_idx    <= w_idx;
        r_wcnt   <= '0;
        r_victim <= w_new_victim;
        r_misses <= r_misses + CNT_W'(1);
        r_lines[w_new_victim][w_idx].valid <= 1'b0;
      end
      if (w_accept) begin
        r_lines[r_victim][r_idx].data[r_wcnt] <= iload;
        r_wcnt <= r_wcnt + OFF_S'(1);
      end
      if (w_last) begin
        r_lines[r_victim][r_idx].valid <= 1'b1;
        r_lines[r_victim][r_idx].tag   <= r_tag;
      end
      // Placed last so a flush overrides a same-cycle line validation.
      if (iflush) begin
        for (int w = 0; w < WAYS; w++) begin
          for (int s = 0; s < SETS; s++) begin
            r_lines[w][s].valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc with an address-level reference model and per-cycle compare.
module tb_icache_assoc;

  localparam int unsigned WAYS  = 2;
  localparam int unsigned SETS  = 8;
  localparam int unsigned WORDS = 2;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned BLK   = 4 * WORDS;
  localparam logic [31:0] K     = 32'h5A5A_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmem_busy;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int checks = 0;
  int errors = 0;

  // memory returns address xor a constant
  assign iload = iaddr ^ K;

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmem_busy(dmem_busy), .iflush(iflush), .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (block base addresses + use timestamps)
  bit          mv    [WAYS][SETS];
  logic [31:0] mb    [WAYS][SETS];
  logic [31:0] md    [WAYS][SETS][WORDS];
  int          mlast [WAYS][SETS];
  int          stamp;
  bit          mfill;
  logic [31:0] mbase;
  int          mw;
  int          mvic;
  logic [31:0] mh;
  logic [31:0] mm;

  function automatic int set_of(input logic [31:0] a);
    return int'((a / BLK) % SETS);
  endfunction

  function automatic bit lookup(input logic [31:0] a, output int way);
    way = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (mv[w][set_of(a)] && (mb[w][set_of(a)] == a - (a % BLK))) begin
        way = w;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        mv[w][s] = 1'b0; mb[w][s] = 32'h0; mlast[w][s] = 0;
      end
    stamp = 0; mfill = 1'b0; mbase = 32'h0; mw = 0; mvic = 0; mh = 32'h0; mm = 32'h0;
  endtask

  task automatic model_step();
    int w, s, v;
    bit h;
    s = set_of(imemaddr);
    h = lookup(imemaddr, w);
    if (!mfill && imemREN && !iflush && h) begin
      mh = mh + 32'd1;
      stamp++;
      mlast[w][s] = stamp;
    end else if (!mfill && imemREN && !iflush && !dmem_busy) begin
      v = -1;
      for (int x = WAYS - 1; x >= 0; x--) if (!mv[x][s]) v = x;
      if (v < 0) begin
        v = 0;
        for (int x = 1; x < WAYS; x++) if (mlast[x][s] < mlast[v][s]) v = x;
      end
      mv[v][s] = 1'b0;
      mfill = 1'b1; mbase = imemaddr - (imemaddr % BLK); mw = 0; mvic = v;
      mm = mm + 32'd1;
    end else if (mfill && !iwait) begin
      s = set_of(mbase);
      md[mvic][s][mw] = (mbase + 32'(4 * mw)) ^ K;
      if (mw == WORDS - 1) begin
        if (!iflush) begin
          mv[mvic][s] = 1'b1; mb[mvic][s] = mbase; stamp++; mlast[mvic][s] = stamp;
        end
        mfill = 1'b0;
      end
      mw++;
    end
    if (iflush) begin
      mfill = 1'b0;
      for (int x = 0; x < WAYS; x++)
        for (int y = 0; y < SETS; y++) mv[x][y] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) model_reset();
      else       model_step();
    end
  end

  // ---------------- per-cycle compare and fill monitor
  logic [31:0] acc_q[$];
  int n_iren = 0;

  initial begin
    int w;
    bit eh;
    logic [31:0] el;
    forever begin
      @(negedge CLK);
      eh = !mfill && imemREN && !iflush && lookup(imemaddr, w);
      el = eh ? md[w][set_of(imemaddr)][int'((imemaddr / 4) % WORDS)] : 32'h0;
      chk("ihit", 32'(ihit), 32'(eh));
      chk("imemload", imemload, el);
      chk("iREN", 32'(iREN), 32'(mfill));
      chk("iaddr", iaddr, mfill ? (mbase + 32'(4 * mw)) : 32'h0);
      chk("hit_count", hit_count, mh);
      chk("miss_count", miss_count, mm);
      if (iREN && !iwait) acc_q.push_back(iaddr);
      if (iREN) n_iren++;
    end
  end

  // ---------------- memory responder: word ready on the third request cycle
  initial begin
    bit acc_prev, ren_prev;
    int cnt;
    iwait = 1'b1; cnt = 0;
    forever begin
      @(negedge CLK);
      acc_prev = iREN && !iwait;
      ren_prev = iREN;
      @(posedge CLK);
      #1;
      if (acc_prev)      cnt = 0;
      else if (ren_prev) cnt++;
      else               cnt = 0;
      iwait = !(iREN && (cnt >= 2));
    end
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] word);
    bit got;
    got = 1'b0; word = 32'h0;
    imemREN = 1'b1; imemaddr = a;
    for (int n = 0; n < 80 && !got; n++) begin
      @(negedge CLK);
      if (ihit) begin got = 1'b1; word = imemload; end
    end
    chk("fetch_served", 32'(got), 32'd1);
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    logic [31:0] wd;
    bit seen;
    int hits;
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] wd;
    bit seen;
    int hits;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; dmem_busy = 1'b0; iflush = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iREN", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge CLK); #1; nRST = 1'b1;
    @(posedge CLK); #1;

    // 1: cold miss at 0x40, then two hits
    acc_q.delete();
    fetch(32'h40, wd);
    chk("t1_word0", wd, 32'h5A5A_0040);
    chk("t1_acc_n", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      chk("t1_addr0", acc_q[0], 32'h40);
      chk("t1_addr1", acc_q[1], 32'h44);
    end
    chk("t1_miss", miss_count, 32'd1);
    fetch(32'h44, wd);
    chk("t1_word1", wd, 32'h5A5A_0044);
    chk("t1_miss_after_44", miss_count, 32'd1);

    // 2: LRU eviction in set 0
    fetch(32'h80, wd);
    fetch(32'h40, wd);
    chk("t2_miss_a", miss_count, 32'd2);
    fetch(32'hC0, wd);
    chk("t2_miss_b", miss_count, 32'd3);
    fetch(32'h40, wd);
    chk("t2_40_hits", miss_count, 32'd3);
    fetch(32'h80, wd);
    chk("t2_miss_c", miss_count, 32'd4);

    // 3: miss held off by dmem_busy
    dmem_busy = 1'b1; imemREN = 1'b1; imemaddr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t3_busy_iREN", 32'(iREN), 32'd0);
      chk("t3_busy_ihit", 32'(ihit), 32'd0);
    end
    @(posedge CLK); #1; dmem_busy = 1'b0;
    @(negedge CLK);
    chk("t3_fall_iREN", 32'(iREN), 32'd0);
    @(negedge CLK);
    chk("t3_fill_iREN", 32'(iREN), 32'd1);
    @(posedge CLK); #1;
    fetch(32'h100, wd);
    chk("t3_word", wd, 32'h5A5A_0100);

    // 4: flush after the first word of 0x200
    imemREN = 1'b1; imemaddr = 32'h200; seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge CLK);
      if (iREN && !iwait && (iaddr == 32'h200)) seen = 1'b1;
    end
    chk("t4_word0_seen", 32'(seen), 32'd1);
    @(posedge CLK); #1; iflush = 1'b1; imemREN = 1'b0;
    @(posedge CLK); #1; iflush = 1'b0;
    chk("t4_iREN_low", 32'(iREN), 32'd0);
    fetch(32'h40, wd);
    chk("t4_40_missed", miss_count, 32'd7);
    chk("t4_hits", hit_count, 32'd9);

    // 5: reset in the middle of a fill
    imemREN = 1'b1; imemaddr = 32'h300; seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge CLK);
      if (iREN) seen = 1'b1;
    end
    chk("t5_fill_started", 32'(seen), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t5_iREN_async", 32'(iREN), 32'd0);
    chk("t5_hits_clr", hit_count, 32'd0);
    chk("t5_miss_clr", miss_count, 32'd0);
    @(posedge CLK); #1;
    @(posedge CLK); #1; nRST = 1'b1;
    fetch(32'h300, wd);
    chk("t5_word", wd, 32'h5A5A_0300);
    chk("t5_miss", miss_count, 32'd1);
    chk("t5_hits", hit_count, 32'd1);

    // 6: twenty hits to 0x40 after one fill
    @(posedge CLK); #1; nRST = 1'b0;
    @(posedge CLK); #1; nRST = 1'b1;
    n_iren = 0; hits = 0;
    imemREN = 1'b1; imemaddr = 32'h40;
    for (int n = 0; n < 100 && hits < 20; n++) begin
      @(negedge CLK);
      if (ihit) hits++;
    end
    @(posedge CLK); #1; imemREN = 1'b0;
    @(negedge CLK);
    chk("t6_hits_seen", 32'(hits), 32'd20);
    chk("t6_hit_count", hit_count, 32'd20);
    chk("t6_miss_count", miss_count, 32'd1);
    chk("t6_iren_cycles", 32'(n_iren), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
